mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 40 ++++
 rtl/mdu_iter_core.sv | 59 +++++
 rtl/mdu_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - op codes, FSM encoding and defaults shared by the MDU and decode-side stall logic
package mdu_ctrl_pkg;

    localparam int ITER_CNT_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - unsigned shift-add multiply / restoring divide, one result bit per step
module mdu_iter_core (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] opnd_a,
    input  logic [31:0] opnd_b,
    output logic [63:0] acc
);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [63:0] acc_q;
    logic [63:0] acc_next;
    logic [31:0] opnd_q;
    logic        div_q;
    logic [32:0] add_sum;
    logic [32:0] shifted_r;
    logic        ge;
    logic [31:0] diff;

    always_comb begin
        add_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        shifted_r = acc_q[63:31];
        ge        = shifted_r >= {1'b0, opnd_q};
        // when ge holds the true difference is below 2^32, so the low word is exact
        diff      = shifted_r[31:0] - opnd_q;
        acc_next  = acc_q;
        if (div_q) begin
            if (ge) begin
                acc_next = {diff, acc_q[30:0], 1'b1};
            end else begin
                acc_next = {shifted_r[31:0], acc_q[30:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_next = {add_sum, acc_q[31:1]};
        end else begin
            acc_next = {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            div_q  <= is_div;
            opnd_q <= is_div ? opnd_b : opnd_a;
            acc_q  <= {32'd0, (is_div ? opnd_a : opnd_b)};
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control: FSM, sign fix-up, HI/LO registers and cancel
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int ITER_CNT = ITER_CNT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER_CNT) + 1;

    state_e        state;
    state_e        state_next;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          neg_q;
    logic          neg_r;
    logic [CW-1:0] cnt;
    logic          accept;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [63:0]   acc;
    logic [63:0]   prod_fix;
    logic [31:0]   hi_res;
    logic [31:0]   lo_res;

    assign accept = op_valid && (state == S_IDLE);
    assign abs_a  = is_signed_op(op_q) ? abs32(a_q) : a_q;
    assign abs_b  = is_signed_op(op_q) ? abs32(b_q) : b_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (op_valid && is_multi_cycle(op_code)) begin
                    state_next = S_PREP;
                end
            end
            S_PREP: state_next = cancel ? S_IDLE : S_ITER;
            S_ITER: begin
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (cnt == CW'(ITER_CNT - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
                done       = !cancel;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept && is_multi_cycle(op_code)) begin
                op_q <= op_code;
                a_q  <= src_a;
                b_q  <= src_b;
            end
            if (state == S_PREP) begin
                cnt   <= '0;
                neg_q <= is_signed_op(op_q) && (a_q[31] ^ b_q[31]);
                neg_r <= is_signed_op(op_q) && a_q[31];
            end else if (state == S_ITER) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    mdu_iter_core u_core (
        .clk    (clk),
        .resetn (resetn),
        .load   (state == S_PREP),
        .step   (state == S_ITER),
        .is_div (is_div_op(op_q)),
        .opnd_a (abs_a),
        .opnd_b (abs_b),
        .acc    (acc)
    );

    // MIN_INT / -1 needs no special case: the negated magnitude wraps back to 0x80000000
    always_comb begin
        prod_fix = neg_q ? (~acc + 64'd1) : acc;
        hi_res   = prod_fix[63:32];
        lo_res   = prod_fix[31:0];
        if (is_div_op(op_q)) begin
            if (b_q == 32'd0) begin
                hi_res = a_q;
                lo_res = 32'hFFFF_FFFF;
            end else begin
                lo_res = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
                hi_res = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && (op_code == OP_MTHI)) begin
            hi <= src_a;
        end else if (accept && (op_code == OP_MTLO)) begin
            lo <= src_a;
        end else if ((state == S_FIX) && !cancel) begin
            hi <= hi_res;
            lo <= lo_res;
        end
    end

endmodule
